ram_1w1r_bypass: RTL

//  Simple dual-port RAM: one write port, one read port, same clock, any byte-multiple width.

---
 rtl/ram_1w1r_bypass_pkg.sv | 19 +
 rtl/ram_1w1r_array.sv | 46 ++++
 rtl/ram_1w1r_bypass.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_1w1r_bypass_pkg.sv
// Shared definitions for the 1W1R bypass RAM: clear-engine state encoding
// and byte-lane helpers used by the top level and the storage array.
package ram_1w1r_bypass_pkg;

  // Clear engine states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Every lane covers one byte of the data word
  localparam int LANE_BITS = 8;

  // Number of byte lanes in a data word of the given width
  function automatic int lane_count(input int dwidth);
    return dwidth / LANE_BITS;
  endfunction

endpackage

// File: rtl/ram_1w1r_array.sv
// Storage array for ram_1w1r_bypass. Holds only the memory, the byte-lane
// write loop and the registered read. Nothing here is reset, so synthesis
// can map it onto block RAM with per-byte write enables.
module ram_1w1r_array
  import ram_1w1r_bypass_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int MW     = lane_count(DWIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MW-1:0]     wmask,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [DWIDTH-1:0] mem [DEPTH];

  logic [DWIDTH-1:0] rdata_reg;

  // Byte-lane write: only lanes with their mask bit set are touched
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < MW; k++) begin
        if (wmask[k]) begin
          mem[waddr][k*LANE_BITS +: LANE_BITS] <= wdata[k*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  // Registered read; returns the pre-write contents on a same-edge collision
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_1w1r_bypass.sv
// Simple dual-port RAM with one write and one read port on a shared clock.
// Adds per-byte write-through bypass for same-address read/write collisions,
// an optional output register and a zero-fill clear engine that owns the
// write port while it runs.
module ram_1w1r_bypass
  import ram_1w1r_bypass_pkg::*;
#(
  parameter  int DEPTH          = 64,
  parameter  int DWIDTH         = 32,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AWIDTH         = $clog2(DEPTH),
  localparam int MW             = lane_count(DWIDTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we_n,
  input  logic [MW-1:0]     i_wmask,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re_n,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_clr,
  output logic              o_busy
);

  // Reject geometries the lane logic cannot represent
  generate
    if ((DWIDTH % LANE_BITS) != 0 || DWIDTH < 8 || DWIDTH > 512 || DEPTH < 2) begin : g_bad_params
      $error("ram_1w1r_bypass: DWIDTH must be a multiple of 8 in 8..512 and DEPTH must be >= 2");
    end
  endgenerate

  localparam int                AW1         = AWIDTH + 1;
  localparam logic [AWIDTH:0]   DEPTH_L     = AW1'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR   = AWIDTH'(DEPTH - 1);
  localparam clr_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  // Clear engine
  clr_state_t        state_reg, state_next;
  logic [AWIDTH-1:0] clr_addr_reg, clr_addr_next;
  logic              busy;

  // User port qualification
  logic              waddr_ok;
  logic              raddr_ok;
  logic              wr_user;
  logic              rd_acc;
  logic              collide;

  // Array port after the clear/user mux
  logic              arr_we;
  logic [MW-1:0]     arr_wmask;
  logic [AWIDTH-1:0] arr_waddr;
  logic [DWIDTH-1:0] arr_wdata;
  logic              arr_re;
  logic [DWIDTH-1:0] arr_rdata;

  // First read stage: bypass information aligned with the array output
  logic              v1_reg;
  logic              oor_reg;
  logic [MW-1:0]     coll_mask_reg;
  logic [DWIDTH-1:0] byp_data_reg;
  logic [DWIDTH-1:0] merged;

  // Last completed read, so o_rdata can hold between reads
  logic [DWIDTH-1:0] data_reg;

  assign busy   = (state_reg == ST_CLEAR);
  assign o_busy = busy;

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two
  assign waddr_ok = ({1'b0, i_waddr} < DEPTH_L);
  assign raddr_ok = ({1'b0, i_raddr} < DEPTH_L);

  // A write with an empty mask changes nothing, so it is not treated as a write
  assign wr_user = !i_we_n && !busy && waddr_ok && (|i_wmask);
  assign rd_acc  = !i_re_n && !busy;
  assign collide = rd_acc && wr_user && (i_raddr == i_waddr);

  // Clear FSM state register; reset optionally launches a zero-fill
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= RESET_STATE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // Clear FSM next state: one word per cycle, leave after the last address
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_clr) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_reg == LAST_ADDR) begin
          state_next    = ST_IDLE;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + AWIDTH'(1);
        end
      end
      default: begin
        state_next    = ST_IDLE;
        clr_addr_next = '0;
      end
    endcase
  end

  // Write-port mux: the clear engine takes the port and writes zero to every lane
  always_comb begin
    arr_we    = wr_user;
    arr_wmask = i_wmask;
    arr_waddr = i_waddr;
    arr_wdata = i_wdata;
    if (busy) begin
      arr_we    = 1'b1;
      arr_wmask = '1;
      arr_waddr = clr_addr_reg;
      arr_wdata = '0;
    end
  end

  // Out-of-range reads never touch the array; their result is forced to zero
  assign arr_re = rd_acc && raddr_ok;

  ram_1w1r_array #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .MW     (MW)
  ) u_array (
    .clk   (i_clk),
    .we    (arr_we),
    .wmask (arr_wmask),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (i_raddr),
    .rdata (arr_rdata)
  );

  // Capture collision lanes and write data alongside the array read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_reg        <= 1'b0;
      oor_reg       <= 1'b0;
      coll_mask_reg <= '0;
      byp_data_reg  <= '0;
    end else begin
      v1_reg        <= rd_acc;
      oor_reg       <= rd_acc && !raddr_ok;
      coll_mask_reg <= collide ? i_wmask : '0;
      byp_data_reg  <= i_wdata;
    end
  end

  // Per-lane merge: colliding lanes take the new write data
  genvar gi;
  generate
    for (gi = 0; gi < MW; gi++) begin : g_merge
      assign merged[gi*LANE_BITS +: LANE_BITS] =
        oor_reg            ? {LANE_BITS{1'b0}} :
        coll_mask_reg[gi]  ? byp_data_reg[gi*LANE_BITS +: LANE_BITS] :
                             arr_rdata[gi*LANE_BITS +: LANE_BITS];
    end
  endgenerate

  // Remember each completed read; doubles as the output register when enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg <= '0;
    end else if (v1_reg) begin
      data_reg <= merged;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic v2_reg;

      // Valid follows the data register by one extra stage
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v2_reg <= 1'b0;
        end else begin
          v2_reg <= v1_reg;
        end
      end

      assign o_rdata  = data_reg;
      assign o_rvalid = v2_reg;
    end else begin : g_out_direct
      // Present the merge directly in the completing cycle, otherwise hold
      assign o_rdata  = v1_reg ? merged : data_reg;
      assign o_rvalid = v1_reg;
    end
  endgenerate

endmodule
